// File: rtl/y86_hazard_ctrl_p_pkg.sv
// Shared Y86 constants and the hazard-controller state type.
// Imported by the hazard control unit (optional perf counters: HAZ_PERF_CNT_EN).
package y86_pkg;

    localparam int I_HALT   = 4'h0;
    localparam int I_NOP    = 4'h1;
    localparam int I_RRMOVQ = 4'h2;
    localparam int I_IRMOVQ = 4'h3;
    localparam int I_RMMOVQ = 4'h4;
    localparam int I_MRMOVQ = 4'h5;
    localparam int I_OPQ    = 4'h6;
    localparam int I_JXX    = 4'h7;
    localparam int I_CALL   = 4'h8;
    localparam int I_RET    = 4'h9;
    localparam int I_PUSHQ  = 4'hA;
    localparam int I_POPQ   = 4'hB;

    localparam int STAT_AOK = 1;
    localparam int STAT_HLT = 2;
    localparam int STAT_ADR = 3;
    localparam int STAT_INS = 4;

    localparam int REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } haz_state_t;

    // HLT, ADR and INS all stop the pipeline; AOK and unused codes do not.
    function automatic logic stat_is_exc(input int unsigned stat);
        return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
    endfunction

endpackage

// File: rtl/y86_hazard_ctrl_p_if.sv
// Pipeline-side bundle for the hazard controller: stage status in, stall/bubble controls out.
// The perf counter outputs (HAZ_PERF_CNT_EN) are plain ports on the top, not part of this bundle.
interface y86_hazard_ctrl_p_if #(
    parameter int ICODE_W = 4,
    parameter int REG_AW  = 4,
    parameter int STAT_W  = 3
);
    logic [ICODE_W-1:0] D_icode;
    logic [REG_AW-1:0]  d_srcA;
    logic [REG_AW-1:0]  d_srcB;
    logic [ICODE_W-1:0] E_icode;
    logic [REG_AW-1:0]  E_dstM;
    logic               e_Cnd;
    logic [ICODE_W-1:0] M_icode;
    logic [STAT_W-1:0]  m_stat;
    logic [STAT_W-1:0]  W_stat;
    logic               dmem_req;
    logic               dmem_ready;

    logic F_stall, D_stall, E_stall, M_stall, W_stall;
    logic D_bubble, E_bubble, M_bubble, W_bubble;
    logic               halted;
    logic [STAT_W-1:0]  halt_stat;
    logic               mem_tmo;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode,
               m_stat, W_stat, dmem_req, dmem_ready,
        input  F_stall, D_stall, E_stall, M_stall, W_stall,
               D_bubble, E_bubble, M_bubble, W_bubble,
               halted, halt_stat, mem_tmo
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode,
               m_stat, W_stat, dmem_req, dmem_ready,
        output F_stall, D_stall, E_stall, M_stall, W_stall,
               D_bubble, E_bubble, M_bubble, W_bubble,
               halted, halt_stat, mem_tmo
    );

endinterface

// File: rtl/y86_hazard_ctrl_p_sat_counter.sv
// Saturating event counter used for the hazard perf counters (HAZ_PERF_CNT_EN builds).
module haz_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/y86_hazard_ctrl_p.sv
// Y86 pipeline hazard/control unit: per-stage stall/bubble, memory wait with timeout, latched halt.
// Define HAZ_PERF_CNT_EN to add saturating hazard event counters as extra output ports.
module y86_hazard_ctrl_p
    import y86_pkg::*;
#(
    parameter int ICODE_W = 4,
    parameter int REG_AW  = 4,
    parameter int STAT_W  = 3,
    parameter int MEM_TMO = 16,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    y86_hazard_ctrl_p_if.slave pipe
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt_loaduse,
    output logic [CNT_W-1:0]  cnt_ret,
    output logic [CNT_W-1:0]  cnt_mispred,
    output logic [CNT_W-1:0]  cnt_memwait
`endif
);

    localparam int TW = (MEM_TMO > 2) ? $clog2(MEM_TMO) : 1;
    localparam logic [TW-1:0] CNT_MAX = TW'(MEM_TMO - 1);

    if (MEM_TMO < 2 || CNT_W < 1) begin : g_param_check
        $error("y86_hazard_ctrl_p: MEM_TMO must be >= 2 and CNT_W >= 1");
    end

    haz_state_t        state_reg, state_next;
    logic [TW-1:0]     wait_cnt_reg, wait_cnt_next;
    logic [STAT_W-1:0] halt_stat_reg, halt_stat_next;
    logic              mem_tmo_reg, mem_tmo_next;

    logic loaduse, ret_any, mispred, m_exc, w_exc;
    logic mem_miss, mem_stall, run_active;

    always_comb begin
        loaduse = ((pipe.E_icode == ICODE_W'(I_MRMOVQ)) || (pipe.E_icode == ICODE_W'(I_POPQ)))
               && (pipe.E_dstM != {REG_AW{1'b1}})
               && ((pipe.E_dstM == pipe.d_srcA) || (pipe.E_dstM == pipe.d_srcB));
        ret_any = (pipe.D_icode == ICODE_W'(I_RET)) || (pipe.E_icode == ICODE_W'(I_RET))
               || (pipe.M_icode == ICODE_W'(I_RET));
        mispred = (pipe.E_icode == ICODE_W'(I_JXX)) && !pipe.e_Cnd;
        m_exc   = stat_is_exc(32'(pipe.m_stat));
        w_exc   = stat_is_exc(32'(pipe.W_stat));
        mem_miss = pipe.dmem_req && !pipe.dmem_ready;
    end

    // A fresh miss in RUN stalls immediately, unless W is retiring an exception (halt wins).
    // In MEM_WAIT the stall drops in the very cycle ready arrives.
    always_comb begin
        mem_stall  = 1'b0;
        run_active = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_RUN:      mem_stall = mem_miss && !w_exc;
                ST_MEM_WAIT: mem_stall = !pipe.dmem_ready;
                default:     mem_stall = 1'b0;
            endcase
            run_active = (state_reg != ST_HALTED) && !mem_stall;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        halt_stat_next = halt_stat_reg;
        mem_tmo_next   = mem_tmo_reg;
        case (state_reg)
            ST_RUN: begin
                if (w_exc) begin
                    state_next     = ST_HALTED;
                    halt_stat_next = pipe.W_stat;
                end else if (mem_miss) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = TW'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (pipe.dmem_ready) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == CNT_MAX) begin
                    state_next     = ST_HALTED;
                    halt_stat_next = STAT_W'(STAT_ADR);
                    mem_tmo_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            halt_stat_reg <= STAT_W'(STAT_AOK);
            mem_tmo_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            halt_stat_reg <= halt_stat_next;
            mem_tmo_reg   <= mem_tmo_next;
        end
    end

    always_comb begin
        pipe.F_stall  = 1'b0;
        pipe.D_stall  = 1'b0;
        pipe.E_stall  = 1'b0;
        pipe.M_stall  = 1'b0;
        pipe.W_stall  = 1'b0;
        pipe.D_bubble = 1'b0;
        pipe.E_bubble = 1'b0;
        pipe.M_bubble = 1'b0;
        pipe.W_bubble = 1'b0;
        if (rst) begin
            pipe.F_stall = 1'b0;
        end else if (state_reg == ST_HALTED) begin
            pipe.F_stall = 1'b1;
            pipe.D_stall = 1'b1;
            pipe.E_stall = 1'b1;
            pipe.M_stall = 1'b1;
            pipe.W_stall = 1'b1;
        end else if (mem_stall) begin
            pipe.F_stall  = 1'b1;
            pipe.D_stall  = 1'b1;
            pipe.E_stall  = 1'b1;
            pipe.M_stall  = 1'b1;
            pipe.W_bubble = 1'b1;
        end else begin
            pipe.F_stall  = loaduse || ret_any;
            pipe.D_stall  = loaduse;
            pipe.D_bubble = mispred || (ret_any && !loaduse);
            pipe.E_bubble = mispred || loaduse;
            pipe.M_bubble = m_exc || w_exc;
            pipe.W_stall  = w_exc;
        end
    end

    assign pipe.halted    = (state_reg == ST_HALTED);
    assign pipe.halt_stat = halt_stat_reg;
    assign pipe.mem_tmo   = mem_tmo_reg;

`ifdef HAZ_PERF_CNT_EN
    haz_sat_counter #(.CNT_W(CNT_W)) u_cnt_loaduse (
        .clk(clk), .rst(rst), .inc(run_active && loaduse), .clr(1'b0), .count(cnt_loaduse)
    );
    haz_sat_counter #(.CNT_W(CNT_W)) u_cnt_ret (
        .clk(clk), .rst(rst), .inc(run_active && ret_any), .clr(1'b0), .count(cnt_ret)
    );
    haz_sat_counter #(.CNT_W(CNT_W)) u_cnt_mispred (
        .clk(clk), .rst(rst), .inc(run_active && mispred), .clr(1'b0), .count(cnt_mispred)
    );
    haz_sat_counter #(.CNT_W(CNT_W)) u_cnt_memwait (
        .clk(clk), .rst(rst), .inc(mem_stall), .clr(1'b0), .count(cnt_memwait)
    );
`else
    logic unused_run_active;
    assign unused_run_active = run_active;
`endif

endmodule

// File: tb/tb_y86_hazard_ctrl_p.sv
// Scoreboard bench for y86_hazard_ctrl_p: directed hazard cases, then randomized traffic.
module tb_y86_hazard_ctrl_p;

    localparam int TMO = 5;
    localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    y86_hazard_ctrl_p_if pipe ();

    y86_hazard_ctrl_p #(.MEM_TMO(TMO)) dut (
        .clk  (clk),
        .rst  (rst),
        .pipe (pipe)
    );

    typedef struct packed {
        logic [4:0] stall;   // F D E M W
        logic [3:0] bubble;  // D E M W
        logic       halted;
        logic       tmo;
        logic [2:0] hs;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    string cur_tag;
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: halted flag, consecutive memory-miss cycles so far, latched status.
    bit       m_halted;
    int       m_misses;
    logic [2:0] m_hs;
    bit       m_tmo;

    function automatic bit is_exc(input logic [2:0] s);
        return s inside {HLT, ADR, INS};
    endfunction

    function automatic obs_t predict();
        obs_t o;
        bit lu, rt, mp, we, mem_hold;
        o = '0;
        o.hs = AOK;
        if (rst) return o;
        if (m_halted) begin
            o.stall = 5'b11111;
            o.halted = 1'b1;
            o.hs = m_hs;
            o.tmo = m_tmo;
            return o;
        end
        lu = (pipe.E_icode == 4'd5 || pipe.E_icode == 4'd11) && pipe.E_dstM != 4'd15
             && (pipe.E_dstM == pipe.d_srcA || pipe.E_dstM == pipe.d_srcB);
        rt = (pipe.D_icode == 4'd9) || (pipe.E_icode == 4'd9) || (pipe.M_icode == 4'd9);
        mp = (pipe.E_icode == 4'd7) && !pipe.e_Cnd;
        we = is_exc(pipe.W_stat);
        if (m_misses > 0) mem_hold = !pipe.dmem_ready;
        else              mem_hold = pipe.dmem_req && !pipe.dmem_ready && !we;
        if (mem_hold) begin
            o.stall  = 5'b11110;
            o.bubble = 4'b0001;
        end else begin
            o.stall  = {lu || rt, lu, 1'b0, 1'b0, we};
            o.bubble = {mp || (rt && !lu), mp || lu, is_exc(pipe.m_stat) || we, 1'b0};
        end
        return o;
    endfunction

    task automatic model_reset();
        m_halted = 0;
        m_misses = 0;
        m_hs = AOK;
        m_tmo = 0;
    endtask

    task automatic model_edge();
        if (rst || m_halted) begin
            if (rst) model_reset();
        end else if (m_misses == 0) begin
            if (is_exc(pipe.W_stat)) begin
                m_halted = 1;
                m_hs = pipe.W_stat;
            end else if (pipe.dmem_req && !pipe.dmem_ready) begin
                m_misses = 1;
            end
        end else if (pipe.dmem_ready) begin
            m_misses = 0;
        end else begin
            m_misses++;
            if (m_misses == TMO) begin
                m_halted = 1;
                m_hs = ADR;
                m_tmo = 1;
                m_misses = 0;
            end
        end
    endtask

    // One clock of stimulus: inputs already driven; queue the prediction, let the monitor check.
    task automatic cycle(input string tag);
        if (rst) model_reset();
        exp_q.push_back(predict());
        tag_q.push_back(tag);
        @(negedge clk);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        pipe.D_icode = 4'd1; pipe.E_icode = 4'd1; pipe.M_icode = 4'd1;
        pipe.d_srcA = 4'd15; pipe.d_srcB = 4'd15; pipe.E_dstM = 4'd15;
        pipe.e_Cnd = 1'b1; pipe.m_stat = AOK; pipe.W_stat = AOK;
        pipe.dmem_req = 1'b0; pipe.dmem_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a.stall  = {pipe.F_stall, pipe.D_stall, pipe.E_stall, pipe.M_stall, pipe.W_stall};
            a.bubble = {pipe.D_bubble, pipe.E_bubble, pipe.M_bubble, pipe.W_bubble};
            a.halted = pipe.halted;
            a.tmo    = pipe.mem_tmo;
            a.hs     = pipe.halt_stat;
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got stall=%b bub=%b halted=%b tmo=%b hs=%0d, want stall=%b bub=%b halted=%b tmo=%b hs=%0d",
                         t, a.stall, a.bubble, a.halted, a.tmo, a.hs,
                         e.stall, e.bubble, e.halted, e.tmo, e.hs);
            end else begin
                $display("ok   %s: stall=%b bub=%b halted=%b tmo=%b hs=%0d",
                         t, a.stall, a.bubble, a.halted, a.tmo, a.hs);
            end
        end
    end

    initial begin
        quiet();
        rst = 1'b1;
        model_reset();
        cycle("reset0");
        cycle("reset1");
        rst = 1'b0;
        cycle("idle");

        pipe.E_icode = 4'd5; pipe.E_dstM = 4'd3; pipe.d_srcA = 4'd3;
        cycle("loaduse_hit");
        pipe.E_dstM = 4'd15; pipe.d_srcA = 4'd15;
        cycle("loaduse_none");
        quiet();

        pipe.D_icode = 4'd9;              cycle("ret_D");
        pipe.D_icode = 4'd1; pipe.E_icode = 4'd9; cycle("ret_E");
        pipe.E_icode = 4'd1; pipe.M_icode = 4'd9; cycle("ret_M");
        quiet();                          cycle("ret_done");

        pipe.E_icode = 4'd7; pipe.e_Cnd = 1'b0; cycle("mispred");
        pipe.e_Cnd = 1'b1;                      cycle("jxx_taken");
        quiet();

        pipe.dmem_req = 1'b1; pipe.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("mem_wait");
        pipe.dmem_ready = 1'b1;  cycle("mem_ready");
        quiet();                 cycle("mem_after");

        pipe.dmem_req = 1'b1; pipe.dmem_ready = 1'b0;
        for (int i = 0; i < TMO; i++) cycle("tmo_wait");
        for (int i = 0; i < 3; i++) begin
            pipe.dmem_ready = 1'(i & 1);
            cycle("tmo_halted");
        end
        quiet();
        rst = 1'b1; cycle("tmo_reset");
        rst = 1'b0; cycle("tmo_after_reset");

        pipe.W_stat = HLT; cycle("w_hlt");
        pipe.W_stat = AOK; cycle("w_hlt_halted");
        cycle("w_hlt_hold");
        rst = 1'b1; cycle("hlt_reset");
        rst = 1'b0;

        pipe.dmem_req = 1'b1; pipe.dmem_ready = 1'b0;
        cycle("pre_rst_wait");
        cycle("pre_rst_wait2");
        rst = 1'b1; cycle("rst_mid_wait");
        rst = 1'b0; quiet(); cycle("post_rst_run");

        for (int n = 0; n < 400; n++) begin
            rst = (n % 37 == 36);
            pipe.D_icode = 4'($urandom_range(0, 11));
            pipe.E_icode = 4'($urandom_range(0, 11));
            pipe.M_icode = 4'($urandom_range(0, 11));
            pipe.d_srcA  = 4'($urandom_range(0, 15));
            pipe.d_srcB  = 4'($urandom_range(0, 15));
            pipe.E_dstM  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
            pipe.e_Cnd   = 1'($urandom_range(0, 1));
            pipe.m_stat  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : AOK;
            pipe.W_stat  = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(0, 7)) : AOK;
            pipe.dmem_req   = ($urandom_range(0, 2) == 0);
            pipe.dmem_ready = ($urandom_range(0, 2) != 0);
            cycle("random");
        end

        rst = 1'b0;
        quiet();
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
